// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 8 data bits LSB first, one stop bit, 2-flop rx synchronizer.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data and stop bits.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;
  state_t state, state_n;
  logic rx_m, rx_s, tick, stop_tick, good, perr;
  logic [CW-1:0] cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = rx_s ? IDLE : START;
      START:     state_n = !tick ? START : rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:      state_n = (tick && bit_cnt == 3'd7) ? PARITY : DATA;
      PARITY:    state_n = tick ? STOP : PARITY;
`else
      DATA:      state_n = (tick && bit_cnt == 3'd7) ? STOP : DATA;
`endif
      STOP:      state_n = !tick ? STOP : rx_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: state_n = rx_s ? IDLE : WAIT_HIGH;
      default:   state_n = IDLE;
    endcase
  end
  // START samples at the half-bit point; every later sample is one full bit apart.
  always_comb begin
    busy = state != IDLE;
    tick = cnt == (state == START ? HALF : LAST);
    stop_tick = state == STOP && tick;
    good = stop_tick && rx_s && !perr;
  end
`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk)
    if (!rst_n || state == IDLE) perr <= 1'b0;
    else if (state == PARITY && tick) perr <= rx_s ^ (^shift);
`else
  assign perr = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      cnt <= '0;
      bit_cnt <= '0;
      shift <= '0;
      data_out <= '0;
      data_valid <= 1'b0;
      frame_err <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      cnt <= (state == IDLE || tick) ? '0 : cnt + CW'(1);
      bit_cnt <= state == IDLE ? '0 : bit_cnt + 3'(state == DATA && tick);
      if (state == DATA && tick) shift[bit_cnt] <= rx_s;
      if (good) data_out <= shift;
      data_valid <= good;
      frame_err <= stop_tick && !rx_s;
      parity_err <= stop_tick && perr;
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;
  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
  logic [7:0] data_out;
  logic data_valid, frame_err, parity_err, busy;
  int checks = 0, errors = 0, cyc = 0;
  int fe_cnt = 0, pe_cnt = 0, ovl_cnt = 0;
  logic [7:0] vq[$];
  int vt[$];
  logic [7:0] last_good = 8'h00;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data_out(data_out),
    .data_valid(data_valid), .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (data_valid) begin
      vq.push_back(data_out);
      vt.push_back(cyc);
    end
    if (frame_err) fe_cnt++;
    if (parity_err) pe_cnt++;
    if (data_valid && (frame_err || parity_err)) ovl_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_events();
    vq.delete();
    vt.delete();
    fe_cnt = 0;
    pe_cnt = 0;
  endtask

  // Serialises one frame; par_bad flips the even-parity bit when parity is built in.
  task automatic send(input logic [7:0] d, input logic par_bad, input logic stop_bit);
    logic [NB-1:0] bits;
`ifdef UART_RX_PARITY_EN
    bits = {stop_bit, (^d) ^ par_bad, d, 1'b0};
`else
    bits = {stop_bit, d, 1'b0};
    if (par_bad) bits = {stop_bit, d, 1'b0};
`endif
    for (int i = 0; i < NB; i++) begin
      rx = bits[i];
      tick(CPB);
    end
    rx = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data"}, data_out, 8'h00);
    chk({tag, "_valid"}, data_valid, 1'b0);
    chk({tag, "_ferr"}, frame_err, 1'b0);
    chk({tag, "_perr"}, parity_err, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    int t0, lat;
    logic [7:0] d;
    int mode;
    logic stop_b, pbad, exp_v;
    tick(3);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick(5);

    clear_events();
    t0 = cyc;
    send(8'hA5, 1'b0, 1'b1);
    tick(8);
    chk("a5_nvalid", vq.size(), 1);
    if (vq.size() > 0) begin
      chk("a5_data", vq[0], 8'hA5);
      lat = vt[0] - t0;
      chk("a5_latency", (lat >= NB * CPB - 4 && lat <= NB * CPB + 4), 1'b1);
    end
    chk("a5_ferr", fe_cnt, 0);
    last_good = 8'hA5;

    clear_events();
    send(8'h00, 1'b0, 1'b1);
    send(8'hFF, 1'b0, 1'b1);
    tick(8);
    chk("b2b_nvalid", vq.size(), 2);
    if (vq.size() == 2) begin
      chk("b2b_d0", vq[0], 8'h00);
      chk("b2b_d1", vq[1], 8'hFF);
      chk("b2b_gap", vt[1] - vt[0], NB * CPB);
    end
    last_good = 8'hFF;

    clear_events();
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(2);
    chk("glitch_busy_mid", busy, 1'b1);
    tick(6);
    chk("glitch_busy_end", busy, 1'b0);
    tick(20);
    chk("glitch_pulses", vq.size() + fe_cnt + pe_cnt, 0);
    send(8'h3C, 1'b0, 1'b1);
    tick(8);
    chk("3c_nvalid", vq.size(), 1);
    chk("3c_data", data_out, 8'h3C);
    last_good = 8'h3C;

    for (int i = 0; i < 10; i++) begin
      clear_events();
      d = 8'($urandom);
      mode = int'($urandom_range(0, 2));
      stop_b = (mode != 1);
`ifdef UART_RX_PARITY_EN
      pbad = (mode == 2);
`else
      pbad = 1'b0;
`endif
      exp_v = stop_b && !pbad;
      send(d, pbad, stop_b);
      tick(8);
      if (exp_v) last_good = d;
      chk($sformatf("rnd%0d_nvalid", i), vq.size(), {31'd0, exp_v});
      chk($sformatf("rnd%0d_ferr", i), fe_cnt, {31'd0, !stop_b});
      chk($sformatf("rnd%0d_perr", i), pe_cnt, {31'd0, pbad});
      chk($sformatf("rnd%0d_data", i), data_out, last_good);
    end

    clear_events();
    send(8'h55, 1'b0, 1'b0);
    rx = 1'b0;
    tick(100);
    chk("brk_busy_low", busy, 1'b1);
    rx = 1'b1;
    tick(4);
    chk("brk_busy_idle", busy, 1'b0);
    chk("brk_ferr", fe_cnt, 1);
    chk("brk_nvalid", vq.size(), 0);
    chk("brk_data", data_out, last_good);

`ifdef UART_RX_PARITY_EN
    clear_events();
    send(8'h07, 1'b1, 1'b1);
    tick(8);
    chk("par_bad_perr", pe_cnt, 1);
    chk("par_bad_nvalid", vq.size(), 0);
    chk("par_bad_data", data_out, last_good);
    clear_events();
    send(8'h07, 1'b0, 1'b1);
    tick(8);
    chk("par_ok_perr", pe_cnt, 0);
    chk("par_ok_nvalid", vq.size(), 1);
    chk("par_ok_data", data_out, 8'h07);
    last_good = 8'h07;
`else
    chk("noparity_perr_tied", parity_err, 1'b0);
`endif

    // The transmitter is reset with the receiver, so the line returns to idle.
    clear_events();
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = (8'h81 >> i) & 8'h01;
      tick(CPB);
    end
    rx = 1'b0;
    tick(CPB / 2);
    rst_n = 1'b0;
    rx = 1'b1;
    tick();
    rst_n = 1'b1;
    check_reset_outputs("midrst");
    tick(200);
    chk("midrst_pulses", vq.size() + fe_cnt + pe_cnt, 0);
    send(8'h81, 1'b0, 1'b1);
    tick(8);
    chk("after_rst_nvalid", vq.size(), 1);
    chk("after_rst_data", data_out, 8'h81);
    chk("overlap", ovl_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 434, giving clock cycles per serial bit (50 MHz / 115200 baud).
REQ-002 The module SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 The module SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 The module SHALL have port rx  input  1  asynchronous serial line; idles high.
REQ-005 The module SHALL have port data_out  output  8  last received byte, LSB first on the line.
REQ-006 The module SHALL have port data_valid  output  1  one-cycle pulse when data_out holds a new good byte.
REQ-007 The module SHALL have port frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-008 The module SHALL have port parity_err  output  1  one-cycle pulse on even-parity mismatch.
REQ-009 The module SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-011 The FSM SHALL have states IDLE, START, DATA, PARITY (macro only), STOP, and WAIT_HIGH.
REQ-012 IDLE SHALL move to START when rx_s = 0, clearing the bit counter and baud counter.
REQ-013 START SHALL resample rx_s at cycle CLKS_PER_BIT/2 (integer division); on 0 go to DATA, on 1 (glitch) return to IDLE with no output pulse.
REQ-014 DATA SHALL sample rx_s every CLKS_PER_BIT cycles from the start mid-point, shifting into bit position 0..7 in order; after bit 7 go to PARITY if compiled in, else STOP.
REQ-015 STOP SHALL sample rx_s one CLKS_PER_BIT after the last data or parity sample.
REQ-016 If the stop sample is 1 and no parity error, data_out SHALL load the byte and data_valid SHALL pulse high on the next cycle; FSM returns to IDLE.
REQ-017 If the stop sample is 0, frame_err SHALL pulse, data_valid SHALL stay low, data_out SHALL hold its previous value, and FSM SHALL enter WAIT_HIGH.
REQ-018 WAIT_HIGH SHALL go to IDLE only on the first cycle rx_s = 1, so a line break yields exactly one frame_err.
REQ-019 Output pulses SHALL last exactly one cycle; data_valid, frame_err, and parity_err SHALL never be high simultaneously, except frame_err with parity_err.
REQ-020 The baud counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL wrap to 0 at each sample point.
REQ-021 A new start bit SHALL be accepted the cycle after returning to IDLE (back-to-back frames, one stop bit).

Reset
REQ-022 With rst_n = 0 at a rising clk edge: state = IDLE; counters = 0; data_out = 8'h00; data_valid, frame_err, parity_err, busy = 0; synchronizer flops = 1.
REQ-023 Reset mid-frame SHALL abandon the frame with no output pulse; reception resumes on the next falling edge after release.

Configuration
REQ-024 Macro UART_RX_PARITY_EN defined: the frame SHALL be start, 8 data bits, even parity bit, stop.
REQ-025 With UART_RX_PARITY_EN, PARITY state SHALL compare the sampled bit with the XOR of the data bits.
REQ-026 With UART_RX_PARITY_EN, a parity mismatch SHALL pulse parity_err in the STOP outcome cycle, suppress data_valid, and leave data_out unchanged.
REQ-027 Macro UART_RX_PARITY_EN undefined: the frame SHALL be start, 8 data bits, stop; PARITY state absent; parity_err tied 0.

Verification (bench CLKS_PER_BIT = 16)
REQ-028 Frame 0xA5, no macro -> data_out = 8'hA5; single data_valid pulse within 160±4 cycles of the rx falling edge; frame_err = 0.
REQ-029 Frames 0x00 then 0xFF back-to-back -> two data_valid pulses, 160 cycles apart; data_out 8'h00 then 8'hFF.
REQ-030 rx low for 4 cycles then high -> no pulses; busy returns to 0 by cycle 12; next frame 0x3C received correctly.
REQ-031 Frame 0x55 with stop bit 0, then line held low 100 cycles -> exactly one frame_err pulse; data_out keeps its previous value; IDLE only after rx rises.
REQ-032 Macro defined, frame 0x07 with parity bit 0 (correct parity is 1) -> parity_err pulse, no data_valid; same frame with parity bit 1 -> data_valid, data_out = 8'h07.
REQ-033 rst_n low for 1 cycle during data bit 4 of 0x81 -> no pulse, all outputs at reset values; the following frame 0x81 is received correctly.
